// File: rtl/stl_uart_pkg.sv
// Shared types for the UART packetizer slice.
// Imported by stl_sync_fifo and stl_uart_packetizer.
package stl_uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_t;

  localparam int TIMEOUT_SAT = 255;

endpackage

// File: rtl/stl_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides.
// DEPTH must be a power of two; a pop never frees room for a same-cycle push.
module stl_sync_fifo
  import stl_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/stl_uart_packetizer.sv
// UART byte stream <-> fixed-size packet packetizer with queued responses.
// Define STL_UART_TIMEOUT_EN to build the partial-packet idle timeout.
module stl_uart_packetizer
  import stl_uart_pkg::*;
#(
  parameter int PACKET_BYTES   = 16,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  byte_t                     rx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output byte_t                     tx_data,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [8*PACKET_BYTES-1:0] req_data,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [8*PACKET_BYTES-1:0] rsp_data,
  output logic [7:0]                timeout_count,
  output logic                      debug_rx_state
);

  localparam int PW = 8 * PACKET_BYTES;
  localparam int IW = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(PACKET_BYTES - 1);

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [IW-1:0] rx_cnt;
  logic          rx_hs;
  logic          req_hs;
  logic          rx_last;
  logic          tmo;

  assign rx_hs          = rx_valid && rx_ready;
  assign req_hs         = req_valid && req_ready;
  assign rx_last        = rx_cnt == LAST;
  assign debug_rx_state = state == RX_HOLD;

  always_ff @(posedge clk) begin
    if (reset) state <= RX_COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    req_valid = 1'b0;
    unique case (state)
      RX_COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid && rx_last) state_nxt = RX_HOLD;
      end
      RX_HOLD: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = RX_COLLECT;
      end
      default: state_nxt = RX_COLLECT;
    endcase
  end

  // Count parks at LAST while holding; the req handshake rewinds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= '0;
      req_data <= '0;
    end else if (rx_hs) begin
      req_data[{rx_cnt, 3'b000} +: 8] <= rx_data;
      if (!rx_last) rx_cnt <= rx_cnt + 1'b1;
    end else if (req_hs || tmo) begin
      rx_cnt <= '0;
    end
  end

`ifdef STL_UART_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_cnt;
  logic          armed;

  assign armed = (state == RX_COLLECT) && (rx_cnt != '0) && !rx_hs;
  assign tmo   = armed && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt      <= '0;
      timeout_count <= '0;
    end else begin
      if (!armed || tmo) idle_cnt <= '0;
      else               idle_cnt <= idle_cnt + 1'b1;
      if (tmo && timeout_count != 8'(TIMEOUT_SAT))
        timeout_count <= timeout_count + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo           = 1'b0;
  assign timeout_count = '0;
`endif

  logic          f_valid;
  logic          f_ready;
  logic [PW-1:0] f_data;
  logic [PW-1:0] sh;
  logic [IW-1:0] tx_idx;
  logic          busy;
  logic          tx_hs;
  logic          tx_last;

  stl_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rsp_valid),
    .in_ready  (rsp_ready),
    .in_data   (rsp_data),
    .out_valid (f_valid),
    .out_ready (f_ready),
    .out_data  (f_data)
  );

  assign tx_valid = busy;
  assign tx_data  = sh[7:0];
  assign tx_hs    = busy && tx_ready;
  assign tx_last  = tx_idx == LAST;
  // Reload on the last byte's handshake keeps packets bubble-free.
  assign f_ready  = !busy || (tx_hs && tx_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      sh     <= '0;
      tx_idx <= '0;
    end else if (f_valid && f_ready) begin
      busy   <= 1'b1;
      sh     <= f_data;
      tx_idx <= '0;
    end else if (tx_hs) begin
      sh     <= sh >> 8;
      tx_idx <= tx_idx + 1'b1;
      if (tx_last) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stl_uart_packetizer.sv
// Scoreboard bench for stl_uart_packetizer (16-byte packets, depth 2, timeout 100).
// Timeout scenarios follow STL_UART_TIMEOUT_EN as the DUT does.
module tb_stl_uart_packetizer;
  import stl_uart_pkg::*;

  localparam int PB  = 16;
  localparam int DEP = 2;
  localparam int TO  = 100;
  localparam int PW  = 8 * PB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  byte_t         rx_data = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  byte_t         tx_data;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [PW-1:0] req_data;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready;
  logic [PW-1:0] rsp_data = '0;
  logic [7:0]    timeout_count;
  logic          debug_rx_state;

  stl_uart_packetizer #(
    .PACKET_BYTES   (PB),
    .RSP_DEPTH      (DEP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .timeout_count  (timeout_count),
    .debug_rx_state (debug_rx_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_req[$];
  byte_t         exp_tx[$];

  task automatic check(input bit ok, input string name,
                       input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      logic [PW-1:0] e;
      if (exp_req.size() == 0) begin
        check(1'b0, "req_unexpected", req_data, '0);
      end else begin
        e = exp_req.pop_front();
        check(req_data === e, "req_data", req_data, e);
      end
    end
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      byte_t e;
      if (exp_tx.size() == 0) begin
        check(1'b0, "tx_unexpected", PW'(tx_data), '0);
      end else begin
        e = exp_tx.pop_front();
        check(tx_data === e, "tx_data", PW'(tx_data), PW'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte_t b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check(1'b0, "rx_wait_bound", PW'(n), PW'(1000));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input logic [PW-1:0] p, input int from, input int upto);
    for (int k = from; k < upto; k++) send_byte(p[8*k +: 8]);
  endtask

  task automatic push_rsp(input logic [PW-1:0] d);
    int n;
    n = 0;
    for (int k = 0; k < PB; k++) exp_tx.push_back(d[8*k +: 8]);
    rsp_valid = 1'b1;
    rsp_data  = d;
    @(negedge clk);
    while (!rsp_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_ready) check(1'b0, "rsp_wait_bound", PW'(n), PW'(1000));
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  // Expects n tx handshakes on n consecutive cycles starting next negedge.
  task automatic drain(input int n, input string name);
    int hs;
    int cyc;
    hs  = 0;
    cyc = 0;
    while (hs < n && cyc < n + 200) begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) hs++;
    end
    check(hs == n && cyc == n, name, PW'(cyc), PW'(n));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ramp(input byte_t base);
    logic [PW-1:0] p;
    for (int k = 0; k < PB; k++) p[8*k +: 8] = base + byte_t'(k);
    return p;
  endfunction

  initial begin
    logic [PW-1:0] p;
    int hs;
    int cyc;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(rx_ready === 1'b1, "rst_rx_ready", PW'(rx_ready), PW'(1));
    check(req_valid === 1'b0, "rst_req_valid", PW'(req_valid), '0);
    check(tx_valid === 1'b0, "rst_tx_valid", PW'(tx_valid), '0);
    check(tx_data === 8'h00, "rst_tx_data", PW'(tx_data), '0);
    check(rsp_ready === 1'b1, "rst_rsp_ready", PW'(rsp_ready), PW'(1));
    check(timeout_count === 8'h00, "rst_timeout_count", PW'(timeout_count), '0);
    check(req_data === '0, "rst_req_data", req_data, '0);
    tick();
    reset = 1'b0;
    tick();

    // Request assembly with backpressure
    p = 128'h0F0E0D0C0B0A09080706050403020100;
    exp_req.push_back(p);
    send_range(p, 0, PB);
    @(negedge clk);
    check(req_valid === 1'b1, "req_valid_rise", PW'(req_valid), PW'(1));
    check(rx_ready === 1'b0, "hold_rx_ready", PW'(rx_ready), '0);
    check(debug_rx_state === 1'b1, "hold_debug", PW'(debug_rx_state), PW'(1));
    repeat (4) @(negedge clk);
    check(req_data === p, "hold_req_data", req_data, p);
    check(rx_ready === 1'b0, "hold_rx_ready_late", PW'(rx_ready), '0);
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    @(negedge clk);
    check(rx_ready === 1'b1, "post_req_rx_ready", PW'(rx_ready), PW'(1));
    check(debug_rx_state === 1'b0, "post_req_debug", PW'(debug_rx_state), '0);
    tick();

    // Single response: 2-cycle latency then 16 back-to-back bytes
    tx_ready = 1'b1;
    p = 128'h00112233445566778899AABBCCDDEEFF;
    for (int k = 0; k < PB; k++) exp_tx.push_back(p[8*k +: 8]);
    rsp_valid = 1'b1;
    rsp_data  = p;
    @(negedge clk);
    check(rsp_ready === 1'b1, "rsp_ready_empty", PW'(rsp_ready), PW'(1));
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check(tx_valid === 1'b0, "tx_latency_cycle1", PW'(tx_valid), '0);
    drain(PB, "tx_latency_burst");
    @(negedge clk);
    check(tx_valid === 1'b0, "tx_idle_after", PW'(tx_valid), '0);
    tick();

    // Three queued responses, then a bubble-free 48-byte stream
    tx_ready = 1'b0;
    push_rsp(ramp(8'hA0));
    push_rsp(ramp(8'hB0));
    push_rsp(ramp(8'hC0));
    @(negedge clk);
    check(rsp_ready === 1'b0, "rsp_full", PW'(rsp_ready), '0);
    check(tx_valid === 1'b1, "tx_loaded", PW'(tx_valid), PW'(1));
    check(tx_data === 8'hA0, "tx_head_byte", PW'(tx_data), PW'(8'hA0));
    tick();
    tx_ready = 1'b1;
    drain(3 * PB, "tx_three_packets");

`ifdef STL_UART_TIMEOUT_EN
    req_ready = 1'b1;
    p = ramp(8'h50);
    send_range(p, 0, 5);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    check(timeout_count === 8'd0, "tmo_before_expiry", PW'(timeout_count), '0);
    @(negedge clk);
    check(timeout_count === 8'd1, "tmo_at_expiry", PW'(timeout_count), PW'(1));
    tick();
    p = ramp(8'h60);
    exp_req.push_back(p);
    send_range(p, 0, PB);

    p = ramp(8'h70);
    exp_req.push_back(p);
    send_range(p, 0, 5);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_range(p, 5, PB);
    @(negedge clk);
    check(timeout_count === 8'd1, "tmo_coincide", PW'(timeout_count), PW'(1));
    tick();

    for (int i = 0; i < 300; i++) begin
      send_byte(byte_t'(i));
      repeat (TO + 1) @(posedge clk);
      #1;
    end
    @(negedge clk);
    check(timeout_count === 8'd255, "tmo_saturate", PW'(timeout_count), PW'(255));
    tick();
    req_ready = 1'b0;
`else
    p = ramp(8'h80);
    exp_req.push_back(p);
    send_range(p, 0, 5);
    repeat (10000) tick();
    @(negedge clk);
    check(timeout_count === 8'd0, "no_tmo_count", PW'(timeout_count), '0);
    check(req_valid === 1'b0, "no_tmo_req_valid", PW'(req_valid), '0);
    tick();
    req_ready = 1'b1;
    send_range(p, 5, PB);
    repeat (3) tick();
    req_ready = 1'b0;
`endif

    // Reset mid RX packet and mid TX stream
    p = ramp(8'h90);
    send_range(p, 0, 3);
    tx_ready = 1'b1;
    push_rsp(ramp(8'hD0));
    hs  = 0;
    cyc = 0;
    while (hs < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) hs++;
    end
    check(hs == 8, "tx_before_reset", PW'(hs), PW'(8));
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    reset    = 1'b1;
    exp_tx.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check(tx_valid === 1'b0, "mid_rst_tx_valid", PW'(tx_valid), '0);
    check(tx_data === 8'h00, "mid_rst_tx_data", PW'(tx_data), '0);
    check(rx_ready === 1'b1, "mid_rst_rx_ready", PW'(rx_ready), PW'(1));
    check(rsp_ready === 1'b1, "mid_rst_rsp_ready", PW'(rsp_ready), PW'(1));
    check(timeout_count === 8'd0, "mid_rst_tmo", PW'(timeout_count), '0);
    tick();
    tx_ready = 1'b1;
    hs = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) hs++;
    end
    check(hs == 0, "no_residual_tx", PW'(hs), '0);
    tick();
    p = ramp(8'hE0);
    exp_req.push_back(p);
    send_range(p, 0, PB);
    req_ready = 1'b1;
    repeat (4) tick();
    req_ready = 1'b0;

    check(exp_req.size() == 0, "req_queue_empty", PW'(exp_req.size()), '0);
    check(exp_tx.size() == 0, "tx_queue_empty", PW'(exp_tx.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
